sdpram_bist_ctrl: RTL and testbench

- Synthesizable built-in self-test engine that acts as the initiator on both ports of a simple dual-port block RAM of the PGL_SDPRAM_* family.
- Writes a deterministic address-derived pattern through the write port, then reads it back through the read port and compares each word.
- Runs two passes, true pattern then inverted pattern, and reports pass/fail, an error count and the first failing address.
- Sits beside each on-chip SDPRAM instance; started by the system controller or by a debug register after configuration.

---
 rtl/sdpram_bist_pkg.sv | 23 ++
 rtl/sdpram_bist_ctrl_if.sv | 33 +++
 rtl/sdpram_bist_chk.sv | 88 ++++++++
 rtl/sdpram_bist_ctrl.sv | 142 ++++++++++++++
 tb/tb_sdpram_bist_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdpram_bist_pkg.sv
// Shared definitions for the SDPRAM built-in self-test engine: FSM state
// encoding and the address-derived test pattern.
package sdpram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  // Widest data bus the pattern helper covers; callers cast down to their width.
  localparam int PAT_WIDTH = 32;

  // P(a) = (2**W - 1 - a) mod 2**W is the bitwise complement of a at any
  // width W, so truncating ~a gives P(a) and truncating a gives ~P(a).
  function automatic logic [PAT_WIDTH-1:0] pattern_word(input logic [PAT_WIDTH-1:0] addr,
                                                        input logic               inv);
    pattern_word = inv ? addr : ~addr;
  endfunction

endpackage

// File: rtl/sdpram_bist_ctrl_if.sv
// Bundle of both SDPRAM ports as seen by the BIST initiator (master) and
// by the RAM itself (slave).
interface sdpram_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 9
);

  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic                  ram_rd_clk_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output ram_wr_en,
    output ram_wr_addr,
    output ram_wr_data,
    output ram_rd_addr,
    output ram_rd_clk_en,
    input  ram_rd_data
  );

  modport slave (
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_wr_data,
    input  ram_rd_addr,
    input  ram_rd_clk_en,
    output ram_rd_data
  );

endinterface

// File: rtl/sdpram_bist_chk.sv
// Read-back checker: tracks each issued read through a valid/address delay
// line matching the RAM latency, compares the returning word against the
// expected pattern, and keeps a saturating error count plus the first
// failing address.
module sdpram_bist_chk
  import sdpram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 9,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     issue_i,
  input  logic [ADDR_WIDTH-1:0]    issue_addr_i,
  input  logic                     pass_idx_i,
  input  logic                     cmp_en_i,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o
);

  logic [RD_LATENCY-1:0]    vld_q;
  logic [ADDR_WIDTH-1:0]    adr_q [RD_LATENCY];
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]    first_q, first_d;
  logic                     seen_q, seen_d;
  logic [DATA_WIDTH-1:0]    exp_word;
  logic                     mismatch;

  // Delay line: stage RD_LATENCY-1 lines up with the data the RAM returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) adr_q[i] <= '0;
    end else if (clear_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) adr_q[i] <= '0;
    end else begin
      vld_q[0] <= issue_i;
      adr_q[0] <= issue_addr_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  assign exp_word = DATA_WIDTH'(pattern_word(32'(adr_q[RD_LATENCY-1]), pass_idx_i));
  assign mismatch = cmp_en_i && vld_q[RD_LATENCY-1] && (rd_data_i != exp_word);

  // Next-state of the error counter and first-error capture.
  always_comb begin
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    seen_d    = seen_q;
    if (clear_i) begin
      err_cnt_d = '0;
      first_d   = '0;
      seen_d    = 1'b0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      if (!seen_q) begin
        seen_d  = 1'b1;
        first_d = adr_q[RD_LATENCY-1];
      end
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      first_q   <= '0;
      seen_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      seen_q    <= seen_d;
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/sdpram_bist_ctrl.sv
// BIST engine for one simple dual-port RAM: writes an address-derived
// pattern, reads it back, and repeats with the inverted pattern. The FSM and
// address counter live here; comparison is delegated to sdpram_bist_chk.
module sdpram_bist_ctrl
  import sdpram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 9,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o,
  sdpram_bist_ctrl_if.master       ram
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(RD_LATENCY - 1);

  bist_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pass_q, pass_d;
  logic                  start_acc;
  logic                  wr_en, rd_issue, cmp_en, busy;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // State, address counter and pass index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic and port decode. The address counter is reused as the
  // drain cycle counter, always leaving each phase at zero.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    start_acc = 1'b0;
    wr_en     = 1'b0;
    rd_issue  = 1'b0;
    cmp_en    = 1'b0;
    busy      = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d   = ST_WRITE;
          addr_d    = '0;
          pass_d    = 1'b0;
          start_acc = 1'b1;
        end
      end
      ST_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = addr_q;
        wr_data = DATA_WIDTH'(pattern_word(32'(addr_q), pass_q));
        addr_d  = addr_q + ADDR_WIDTH'(1);
        if (addr_q == ADDR_LAST) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        busy     = 1'b1;
        rd_issue = 1'b1;
        cmp_en   = 1'b1;
        rd_addr  = addr_q;
        addr_d   = addr_q + ADDR_WIDTH'(1);
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
        end
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        cmp_en = 1'b1;
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (addr_q == DRAIN_LAST) begin
          addr_d = '0;
          if (!pass_q) begin
            pass_d  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        pass_d  = 1'b0;
      end
    endcase
  end

  sdpram_bist_chk #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .RD_LATENCY   (RD_LATENCY),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_chk (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (start_acc),
    .issue_i         (rd_issue),
    .issue_addr_i    (addr_q),
    .pass_idx_i      (pass_q),
    .cmp_en_i        (cmp_en),
    .rd_data_i       (ram.ram_rd_data),
    .err_cnt_o       (err_cnt_o),
    .first_err_addr_o(first_err_addr_o)
  );

  assign ram.ram_wr_en     = wr_en;
  assign ram.ram_wr_addr   = wr_addr;
  assign ram.ram_wr_data   = wr_data;
  assign ram.ram_rd_addr   = rd_addr;
  assign ram.ram_rd_clk_en = busy;

  assign busy_o = busy;
  assign done_o = (state_q == ST_DONE);
  assign pass_o = (state_q == ST_DONE) && (err_cnt_o == '0);

endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// Bench for sdpram_bist_ctrl: two engines (read latency 1 and 2) each beside
// a behavioural RAM with injectable read faults; results are predicted by a
// pass/address-level reference model.
module tb_sdpram_bist_ctrl;

  localparam int AW   = 11;
  localparam int DW   = 9;
  localparam int EW   = 3;
  localparam int N    = 1 << AW;
  localparam int MASK = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic busy1, done1, pass1, busy2, done2, pass2;
  logic [EW-1:0] err1, err2;
  logic [AW-1:0] first1, first2;

  int compared = 0;
  int mismatched = 0;
  int sel = 0;
  int faultMode = 0;
  int faultAddr = 0;
  int faultBit = 0;
  int faultVal = 0;

  sdpram_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  sdpram_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  sdpram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(EW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_cnt_o(err1), .first_err_addr_o(first1), .ram(bus1)
  );

  sdpram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .ERR_CNT_WIDTH(EW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_cnt_o(err2), .first_err_addr_o(first2), .ram(bus2)
  );

  always #5 clk = ~clk;

  // Read-path fault applied to the word stored at address a.
  function automatic logic [DW-1:0] faultFn(input int a, input logic [DW-1:0] w);
    logic [DW-1:0] m;
    m = '0;
    m[faultBit] = 1'b1;
    case (faultMode)
      1: faultFn = (a == faultAddr) ? (faultVal != 0 ? (w | m) : (w & ~m)) : w;
      2: faultFn = ~w;
      default: faultFn = w;
    endcase
  endfunction

  // Latency-1 RAM model (no output register).
  logic [DW-1:0] mem1 [N];
  logic [DW-1:0] rdq1;
  always @(posedge clk) begin
    if (bus1.ram_wr_en) mem1[bus1.ram_wr_addr] <= bus1.ram_wr_data;
    if (bus1.ram_rd_clk_en) rdq1 <= faultFn(int'(bus1.ram_rd_addr), mem1[bus1.ram_rd_addr]);
  end
  assign bus1.ram_rd_data = rdq1;

  // Latency-2 RAM model (registered output).
  logic [DW-1:0] mem2 [N];
  logic [DW-1:0] rdq2a, rdq2b;
  always @(posedge clk) begin
    if (bus2.ram_wr_en) mem2[bus2.ram_wr_addr] <= bus2.ram_wr_data;
    if (bus2.ram_rd_clk_en) begin
      rdq2a <= faultFn(int'(bus2.ram_rd_addr), mem2[bus2.ram_rd_addr]);
      rdq2b <= rdq2a;
    end
  end
  assign bus2.ram_rd_data = rdq2b;

  // Observation mux selecting the engine under test.
  logic busyM, doneM, passM, wrEnM, rdEnM;
  logic [EW-1:0] errM;
  logic [AW-1:0] firstM, wrAddrM, rdAddrM;
  logic [DW-1:0] wrDataM;
  always_comb begin
    if (sel == 0) begin
      busyM = busy1; doneM = done1; passM = pass1; errM = err1; firstM = first1;
      wrEnM = bus1.ram_wr_en; wrAddrM = bus1.ram_wr_addr; wrDataM = bus1.ram_wr_data;
      rdAddrM = bus1.ram_rd_addr; rdEnM = bus1.ram_rd_clk_en;
    end else begin
      busyM = busy2; doneM = done2; passM = pass2; errM = err2; firstM = first2;
      wrEnM = bus2.ram_wr_en; wrAddrM = bus2.ram_wr_addr; wrDataM = bus2.ram_wr_data;
      rdAddrM = bus2.ram_rd_addr; rdEnM = bus2.ram_rd_clk_en;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int s, input logic v);
    if (s == 0) start1 = v;
    else start2 = v;
  endtask

  // Expected write word: pass 0 writes (2**DW-1-a) mod 2**DW, pass 1 its complement.
  function automatic int expWord(input int a, input int p);
    int v;
    v = ((MASK - a) % (MASK + 1) + (MASK + 1)) % (MASK + 1);
    return (p != 0) ? (MASK - v) : v;
  endfunction

  // Reference model: walk both passes over all addresses and score mismatches.
  task automatic modelRun(output int errs, output int first);
    bit seen;
    int w, r;
    errs = 0; first = 0; seen = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N; a++) begin
        w = expWord(a, p);
        r = int'(faultFn(a, DW'(w)));
        if (r != w) begin
          if (!seen) begin seen = 1; first = a; end
          if (errs < (1 << EW) - 1) errs++;
        end
      end
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, ":busy"}, 32'(busyM), 0);
    checkOutput({tag, ":done"}, 32'(doneM), 0);
    checkOutput({tag, ":pass"}, 32'(passM), 0);
    checkOutput({tag, ":err"}, 32'(errM), 0);
    checkOutput({tag, ":first"}, 32'(firstM), 0);
    checkOutput({tag, ":wrEn"}, 32'(wrEnM), 0);
    checkOutput({tag, ":wrAddr"}, 32'(wrAddrM), 0);
    checkOutput({tag, ":wrData"}, 32'(wrDataM), 0);
    checkOutput({tag, ":rdAddr"}, 32'(rdAddrM), 0);
    checkOutput({tag, ":rdEn"}, 32'(rdEnM), 0);
  endtask

  // One full test: start held for 'hold' edges, optional extra pulse at edge midAt+1.
  task automatic runTest(input int s, input int hold, input int midAt, input string name);
    int n, errs, first, wrCnt, badCyc, rl, lim, a;
    sel = s;
    rl = s + 1;
    modelRun(errs, first);
    @(negedge clk);
    applyStimulus(s, 1'b1);
    @(negedge clk);
    if (hold <= 1) applyStimulus(s, 1'b0);
    n = 0; wrCnt = 0; badCyc = 0;
    checkOutput({name, ":busyAtStart"}, 32'(busyM), 1);
    checkOutput({name, ":doneCleared"}, 32'(doneM), 0);
    checkOutput({name, ":errCleared"}, 32'(errM), 0);
    checkOutput({name, ":firstCleared"}, 32'(firstM), 0);
    checkOutput({name, ":wrData@0"}, 32'(wrDataM), 'h1FF);
    lim = 6 * (2 * N + rl);
    while (!doneM && n < lim) begin
      if (wrEnM) begin
        a = wrCnt % N;
        if (int'(wrAddrM) != a || int'(wrDataM) != expWord(a, wrCnt / N)) badCyc++;
        wrCnt++;
      end
      if (rdEnM != busyM) badCyc++;
      if (n == 'h1FF) begin
        checkOutput({name, ":wrAddr@1FF"}, 32'(wrAddrM), 'h1FF);
        checkOutput({name, ":wrData@1FF"}, 32'(wrDataM), 0);
      end
      @(negedge clk);
      n++;
      applyStimulus(s, (n < hold) || (n == midAt));
    end
    applyStimulus(s, 1'b0);
    checkOutput({name, ":doneCycle"}, n, 2 * (2 * N + rl));
    checkOutput({name, ":done"}, 32'(doneM), 1);
    checkOutput({name, ":busyEnd"}, 32'(busyM), 0);
    checkOutput({name, ":pass"}, 32'(passM), (errs == 0) ? 1 : 0);
    checkOutput({name, ":errCnt"}, 32'(errM), errs);
    checkOutput({name, ":firstErr"}, 32'(firstM), first);
    checkOutput({name, ":writes"}, wrCnt, 2 * N);
    checkOutput({name, ":badCycles"}, badCyc, 0);
  endtask

  // Assert reset partway through the read phase and check outputs drop at once.
  task automatic resetMidRead(input int s);
    int k;
    sel = s;
    @(negedge clk);
    applyStimulus(s, 1'b1);
    @(negedge clk);
    applyStimulus(s, 1'b0);
    k = N + int'($urandom_range(1, N - 4));
    repeat (k) @(negedge clk);
    checkOutput("rst:wrEnInRead", 32'(wrEnM), 0);
    checkOutput("rst:busyInRead", 32'(busyM), 1);
    rst_n = 1'b0;
    #1;
    checkIdleZero("rstMid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst:staysIdle", 32'(busyM), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    sel = 0;
    checkIdleZero("reset1");
    sel = 1;
    checkIdleZero("reset2");
    rst_n = 1'b1;
    @(negedge clk);

    faultMode = 0;
    runTest(0, 1, int'($urandom_range(2, N - 2)), "clean");

    faultMode = 1; faultAddr = 'h155; faultBit = 0; faultVal = 0;
    runTest(0, 1, -1, "stuck155");
    checkOutput("stuck155:errConst", 32'(errM), 1);
    checkOutput("stuck155:firstConst", 32'(firstM), 'h155);

    faultAddr = int'($urandom_range(0, N - 1));
    faultBit = int'($urandom_range(0, DW - 1));
    faultVal = int'($urandom_range(0, 1));
    runTest(0, 1, -1, "stuckRand");

    faultMode = 2;
    runTest(0, 1, -1, "invert");
    checkOutput("invert:errConst", 32'(errM), 7);
    checkOutput("invert:firstConst", 32'(firstM), 0);

    runTest(0, int'($urandom_range(2, 20)), -1, "heldRestart");

    faultMode = 0;
    runTest(1, 1, int'($urandom_range(2, N - 2)), "lat2");

    resetMidRead(0);
    runTest(0, 1, -1, "afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
